control_unit_mc: RTL and testbench
==================================

CONTROL_UNIT_MC -- requirements
Module: control_unit_mc

Interface
REQ-001 Parameter AluCtrlWidth, default 3: width of alu_control_o, matching the ALU operation select.
REQ-002 clk_i  input  1  single clock; all state updates on rising edge.
REQ-003 rst_ni  input  1  reset, asynchronous, active-low.
REQ-004 op_i  input  7  instruction opcode field [6:0], valid from DECODE onward.
REQ-005 funct3_i  input  3  instruction funct3.
REQ-006 funct7b5_i  input  1  instruction bit 30.
REQ-007 zero_i  input  1  ALU zero flag.
REQ-008 pc_write_o  output  1  PC register enable.
REQ-009 adr_src_o  output  1  memory address select: 0 = PC, 1 = ALUOut.
REQ-010 ir_write_o  output  1  instruction/OldPC register enable.
REQ-011 mem_write_o  output  1  data memory write strobe.
REQ-012 reg_write_o  output  1  register file write strobe.
REQ-013 result_src_o  output  2  result select: 00 ALUOut, 01 Data, 10 ALU result.
REQ-014 alu_src_a_o  output  2  ALU A select: 00 PC, 01 OldPC, 10 rs1 data.
REQ-015 alu_src_b_o  output  2  ALU B select: 00 rs2 data, 01 immediate, 10 constant 4.
REQ-016 alu_control_o  output  AluCtrlWidth  ALU operation: 000 add, 001 sub, 010 and, 011 or, 100 xor, 101 slt.
REQ-017 illegal_o  output  1  one-cycle pulse when an unsupported instruction is decoded.

Function
REQ-018 The block SHALL be a Moore FSM with states FETCH, DECODE, MEMADR, MEMREAD, MEMWB, MEMWRITE, EXECR, EXECI, ALUWB, BEQ, JAL; it has one state-register update per clock.
REQ-019 Transitions:
- FETCH->DECODE.
- DECODE->MEMADR for op 0000011 or 0100011.
- DECODE->EXECR for op 0110011.
- DECODE->EXECI for op 0010011.
- DECODE->BEQ for op 1100011.
- DECODE->JAL for op 1101111.
- DECODE->FETCH otherwise.
- MEMADR->MEMREAD if op[5]=0, else MEMWRITE.
- MEMREAD->MEMWB.
- EXECR, EXECI and JAL->ALUWB.
- MEMWB, MEMWRITE, ALUWB and BEQ->FETCH.
REQ-020 Per-state outputs; all unlisted outputs are 0; aluop 00=add, 01=sub, 10=funct-decode:
- FETCH: ir_write=1, pc_update=1, a=00, b=10, result_src=10, aluop=00.
- DECODE: a=01, b=01, aluop=00.
- MEMADR: a=10, b=01, aluop=00.
- MEMREAD: adr_src=1, result_src=00.
- MEMWB: result_src=01, reg_write=1.
- MEMWRITE: adr_src=1, mem_write=1.
- EXECR: a=10, b=00, aluop=10.
- EXECI: a=10, b=01, aluop=10.
- ALUWB: reg_write=1.
- BEQ: a=10, b=00, aluop=01, branch=1.
- JAL: a=01, b=10, aluop=00, pc_update=1.
REQ-021 pc_write_o SHALL equal pc_update OR (branch AND zero_i), combinationally.
REQ-022 ALU decode with aluop=10 SHALL use funct3_i as follows:
- funct3 000: sub if op_i[5]=1 and funct7b5_i=1, else add.
- funct3 010: slt.
- funct3 100: xor.
- funct3 110: or.
- funct3 111: and.
REQ-023 In DECODE, for op 0110011 or 0010011 with funct3 in {001, 011, 101}, the FSM SHALL go to FETCH and pulse illegal_o.
REQ-024 illegal_o SHALL be high only in the DECODE cycle in which the next state is FETCH.
REQ-025 Instruction latency SHALL be:
- lw: 5 cycles.
- sw, R-type, I-type, jal: 4 cycles.
- beq: 3 cycles.
- illegal: 2 cycles.

Reset
REQ-026 Asserting rst_ni low SHALL force the state to FETCH immediately, including mid-instruction.
REQ-027 While rst_ni is low, pc_write_o, ir_write_o, mem_write_o, reg_write_o and illegal_o SHALL be 0; the selects SHALL hold their FETCH values.
REQ-028 The first rising edge after rst_ni goes high SHALL execute FETCH.

Structure
REQ-029 A shared package SHALL hold:
- the state enum;
- the alu_control encodings, typed as an enum;
- the opcode constants;
- the result, A-select and B-select encodings.
REQ-030 The aluop/funct-to-alu_control mapping SHALL be a combinational sub-module named alu_decoder.

Verification
REQ-031 Scenario add: reset, op=0110011, funct3=000, funct7b5=0 -> state sequence FETCH, DECODE, EXECR, ALUWB; alu_control=000 in EXECR; reg_write=1 only in ALUWB.
REQ-032 Scenario sub: op=0110011, funct3=000, funct7b5=1 -> alu_control=001 in EXECR.
REQ-033 Scenario addi: op=0010011, funct3=000, funct7b5=1 -> alu_control=000 (no sub).
REQ-034 Scenario lw: op=0000011 -> 5-cycle sequence; adr_src=1 in MEMREAD; result_src=01 and reg_write=1 in MEMWB.
REQ-035 Scenario beq: op=1100011 with zero_i=1 -> pc_write=1 in BEQ; with zero_i=0 -> pc_write=0; alu_control=001 in both cases.
REQ-036 Scenario illegal and reset:
- op=0110011, funct3=001 -> illegal_o=1 for exactly one cycle, then FETCH.
- rst_ni low during MEMWRITE -> mem_write_o=0 immediately, and FETCH follows release.

Source files
------------

// File: rtl/control_unit_mc_pkg.sv
// Shared types and encodings for the multicycle control unit: FSM states,
// ALU operation codes, opcodes and datapath select encodings.
package control_unit_mc_pkg;

  typedef enum logic [3:0] {
    S_FETCH,
    S_DECODE,
    S_MEMADR,
    S_MEMREAD,
    S_MEMWB,
    S_MEMWRITE,
    S_EXECR,
    S_EXECI,
    S_ALUWB,
    S_BEQ,
    S_JAL
  } state_e;

  typedef enum logic [2:0] {
    ALU_ADD = 3'b000,
    ALU_SUB = 3'b001,
    ALU_AND = 3'b010,
    ALU_OR  = 3'b011,
    ALU_XOR = 3'b100,
    ALU_SLT = 3'b101
  } alu_ctrl_e;

  typedef enum logic [1:0] {
    ALUOP_ADD   = 2'b00,
    ALUOP_SUB   = 2'b01,
    ALUOP_FUNCT = 2'b10
  } alu_op_e;

  typedef enum logic [1:0] {
    RES_ALUOUT = 2'b00,
    RES_DATA   = 2'b01,
    RES_ALU    = 2'b10
  } result_src_e;

  typedef enum logic [1:0] {
    SRCA_PC    = 2'b00,
    SRCA_OLDPC = 2'b01,
    SRCA_RS1   = 2'b10
  } src_a_e;

  typedef enum logic [1:0] {
    SRCB_RS2  = 2'b00,
    SRCB_IMM  = 2'b01,
    SRCB_FOUR = 2'b10
  } src_b_e;

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_RTYPE  = 7'b0110011;
  localparam logic [6:0] OP_ITYPE  = 7'b0010011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;

  // Per-state control word; pc_update and branch are folded into pc_write later.
  typedef struct packed {
    logic        pc_update;
    logic        branch;
    logic        adr_src;
    logic        ir_write;
    logic        mem_write;
    logic        reg_write;
    result_src_e result_src;
    src_a_e      src_a;
    src_b_e      src_b;
    alu_op_e     alu_op;
  } ctrl_t;

  // Shifts and sltu share funct3 slots the ALU cannot execute.
  function automatic logic is_unsupported_funct3(input logic [2:0] funct3);
    return (funct3 == 3'b001) || (funct3 == 3'b011) || (funct3 == 3'b101);
  endfunction

endpackage

// File: rtl/control_unit_mc_alu_decoder.sv
// Combinational ALU decoder: maps the FSM's aluop and the instruction funct
// fields to the ALU operation select.
module alu_decoder
  import control_unit_mc_pkg::*;
(
  input  alu_op_e    alu_op_i,
  input  logic [2:0] funct3_i,
  input  logic       op_b5_i,
  input  logic       funct7b5_i,
  output alu_ctrl_e  alu_control_o
);

  // NOTE: every always_comb output gets a default first so no path infers a latch.
  always_comb begin
    alu_control_o = ALU_ADD;
    case (alu_op_i)
      ALUOP_ADD: alu_control_o = ALU_ADD;
      ALUOP_SUB: alu_control_o = ALU_SUB;
      ALUOP_FUNCT: begin
        case (funct3_i)
          3'b000: begin
            // Only R-type (op[5]=1) can subtract; addi ignores bit 30.
            if (op_b5_i && funct7b5_i) alu_control_o = ALU_SUB;
            else                       alu_control_o = ALU_ADD;
          end
          3'b010:  alu_control_o = ALU_SLT;
          3'b100:  alu_control_o = ALU_XOR;
          3'b110:  alu_control_o = ALU_OR;
          3'b111:  alu_control_o = ALU_AND;
          default: alu_control_o = ALU_ADD;
        endcase
      end
      default: alu_control_o = ALU_ADD;
    endcase
  end

endmodule

// File: rtl/control_unit_mc.sv
// Multicycle RISC-V control unit: Moore FSM sequencing fetch, decode, memory,
// ALU and branch steps, plus the ALU operation decode.
module control_unit_mc
  import control_unit_mc_pkg::*;
#(
  parameter int AluCtrlWidth = 3
) (
  input  logic                    clk_i,
  input  logic                    rst_ni,
  input  logic [6:0]              op_i,
  input  logic [2:0]              funct3_i,
  input  logic                    funct7b5_i,
  input  logic                    zero_i,
  output logic                    pc_write_o,
  output logic                    adr_src_o,
  output logic                    ir_write_o,
  output logic                    mem_write_o,
  output logic                    reg_write_o,
  output logic [1:0]              result_src_o,
  output logic [1:0]              alu_src_a_o,
  output logic [1:0]              alu_src_b_o,
  output logic [AluCtrlWidth-1:0] alu_control_o,
  output logic                    illegal_o
);

  state_e    state;
  state_e    state_next;
  ctrl_t     ctrl;
  alu_ctrl_e alu_ctrl;
  logic      illegal;

  // NOTE: sequential state uses non-blocking assignments; reset is asynchronous.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) state <= S_FETCH;
    else         state <= state_next;
  end

  always_comb begin
    state_next = S_FETCH;
    case (state)
      S_FETCH: state_next = S_DECODE;
      S_DECODE: begin
        case (op_i)
          OP_LOAD, OP_STORE: state_next = S_MEMADR;
          OP_RTYPE:  state_next = is_unsupported_funct3(funct3_i) ? S_FETCH : S_EXECR;
          OP_ITYPE:  state_next = is_unsupported_funct3(funct3_i) ? S_FETCH : S_EXECI;
          OP_BRANCH: state_next = S_BEQ;
          OP_JAL:    state_next = S_JAL;
          default:   state_next = S_FETCH;
        endcase
      end
      S_MEMADR:  state_next = op_i[5] ? S_MEMWRITE : S_MEMREAD;
      S_MEMREAD: state_next = S_MEMWB;
      S_EXECR, S_EXECI, S_JAL: state_next = S_ALUWB;
      default:   state_next = S_FETCH;
    endcase
  end

  always_comb begin
    ctrl = '0;
    case (state)
      S_FETCH: begin
        ctrl.ir_write   = 1'b1;
        ctrl.pc_update  = 1'b1;
        ctrl.src_a      = SRCA_PC;
        ctrl.src_b      = SRCB_FOUR;
        ctrl.result_src = RES_ALU;
        ctrl.alu_op     = ALUOP_ADD;
      end
      S_DECODE: begin
        ctrl.src_a  = SRCA_OLDPC;
        ctrl.src_b  = SRCB_IMM;
        ctrl.alu_op = ALUOP_ADD;
      end
      S_MEMADR: begin
        ctrl.src_a  = SRCA_RS1;
        ctrl.src_b  = SRCB_IMM;
        ctrl.alu_op = ALUOP_ADD;
      end
      S_MEMREAD: begin
        ctrl.adr_src    = 1'b1;
        ctrl.result_src = RES_ALUOUT;
      end
      S_MEMWB: begin
        ctrl.result_src = RES_DATA;
        ctrl.reg_write  = 1'b1;
      end
      S_MEMWRITE: begin
        ctrl.adr_src   = 1'b1;
        ctrl.mem_write = 1'b1;
      end
      S_EXECR: begin
        ctrl.src_a  = SRCA_RS1;
        ctrl.src_b  = SRCB_RS2;
        ctrl.alu_op = ALUOP_FUNCT;
      end
      S_EXECI: begin
        ctrl.src_a  = SRCA_RS1;
        ctrl.src_b  = SRCB_IMM;
        ctrl.alu_op = ALUOP_FUNCT;
      end
      S_ALUWB: ctrl.reg_write = 1'b1;
      S_BEQ: begin
        ctrl.src_a  = SRCA_RS1;
        ctrl.src_b  = SRCB_RS2;
        ctrl.alu_op = ALUOP_SUB;
        ctrl.branch = 1'b1;
      end
      S_JAL: begin
        ctrl.src_a     = SRCA_OLDPC;
        ctrl.src_b     = SRCB_FOUR;
        ctrl.alu_op    = ALUOP_ADD;
        ctrl.pc_update = 1'b1;
      end
      default: ctrl = '0;
    endcase
  end

  // Unsupported instructions are exactly the decodes that fall straight back to fetch.
  assign illegal = (state == S_DECODE) && (state_next == S_FETCH);

  alu_decoder u_alu_decoder (
    .alu_op_i      (ctrl.alu_op),
    .funct3_i      (funct3_i),
    .op_b5_i       (op_i[5]),
    .funct7b5_i    (funct7b5_i),
    .alu_control_o (alu_ctrl)
  );

  // Reset holds the state in FETCH, so strobes are gated while selects keep FETCH values.
  assign pc_write_o    = rst_ni & (ctrl.pc_update | (ctrl.branch & zero_i));
  assign ir_write_o    = rst_ni & ctrl.ir_write;
  assign mem_write_o   = rst_ni & ctrl.mem_write;
  assign reg_write_o   = rst_ni & ctrl.reg_write;
  assign illegal_o     = rst_ni & illegal;
  assign adr_src_o     = ctrl.adr_src;
  assign result_src_o  = ctrl.result_src;
  assign alu_src_a_o   = ctrl.src_a;
  assign alu_src_b_o   = ctrl.src_b;
  assign alu_control_o = AluCtrlWidth'(alu_ctrl);

endmodule

// File: tb/tb_control_unit_mc.sv
// Directed self-checking bench for control_unit_mc: walks each instruction
// class cycle by cycle and compares the full output word against a local model.
module tb_control_unit_mc;

  logic       clk_i = 1'b0;
  logic       rst_ni;
  logic [6:0] op_i;
  logic [2:0] funct3_i;
  logic       funct7b5_i;
  logic       zero_i;
  logic       pc_write_o, adr_src_o, ir_write_o, mem_write_o, reg_write_o, illegal_o;
  logic [1:0] result_src_o, alu_src_a_o, alu_src_b_o;
  logic [2:0] alu_control_o;

  int n_cmp = 0;
  int n_err = 0;

  control_unit_mc #(.AluCtrlWidth(3)) dut (
    .clk_i         (clk_i),
    .rst_ni        (rst_ni),
    .op_i          (op_i),
    .funct3_i      (funct3_i),
    .funct7b5_i    (funct7b5_i),
    .zero_i        (zero_i),
    .pc_write_o    (pc_write_o),
    .adr_src_o     (adr_src_o),
    .ir_write_o    (ir_write_o),
    .mem_write_o   (mem_write_o),
    .reg_write_o   (reg_write_o),
    .result_src_o  (result_src_o),
    .alu_src_a_o   (alu_src_a_o),
    .alu_src_b_o   (alu_src_b_o),
    .alu_control_o (alu_control_o),
    .illegal_o     (illegal_o)
  );

  always #5 clk_i = ~clk_i;

  // Output word: pc_write adr_src ir_write mem_write reg_write result(2) a(2) b(2) alu(3) illegal
  logic [14:0] obs;
  assign obs = {pc_write_o, adr_src_o, ir_write_o, mem_write_o, reg_write_o,
                result_src_o, alu_src_a_o, alu_src_b_o, alu_control_o, illegal_o};

  typedef enum int {FETCH, DECODE, MEMADR, MEMREAD, MEMWB, MEMWRITE,
                    EXECR, EXECI, ALUWB, BEQ, JAL} st_t;

  localparam logic [14:0] RESET_WORD = {5'b00000, 2'b10, 2'b00, 2'b10, 3'b000, 1'b0};

  function automatic logic [14:0] exp_out(st_t s, logic z, logic [2:0] ex_alu, logic ill);
    logic pcw = 0, adr = 0, irw = 0, mw = 0, rw = 0, il = 0;
    logic [1:0] res = 0, a = 0, b = 0;
    logic [2:0] alu = 0;
    case (s)
      FETCH:    begin irw = 1; pcw = 1; b = 2'b10; res = 2'b10; end
      DECODE:   begin a = 2'b01; b = 2'b01; il = ill; end
      MEMADR:   begin a = 2'b10; b = 2'b01; end
      MEMREAD:  adr = 1;
      MEMWB:    begin res = 2'b01; rw = 1; end
      MEMWRITE: begin adr = 1; mw = 1; end
      EXECR:    begin a = 2'b10; alu = ex_alu; end
      EXECI:    begin a = 2'b10; b = 2'b01; alu = ex_alu; end
      ALUWB:    rw = 1;
      BEQ:      begin a = 2'b10; alu = 3'b001; pcw = z; end
      JAL:      begin a = 2'b01; b = 2'b10; pcw = 1; end
      default:  ;
    endcase
    return {pcw, adr, irw, mw, rw, res, a, b, alu, il};
  endfunction

  // Every test task starts and ends at negedge+1 with the FSM in FETCH.
  task automatic test_reset();
    rst_ni = 1'b0; op_i = 7'b0110011; funct3_i = 3'b000; funct7b5_i = 1'b0; zero_i = 1'b1;
    repeat (2) @(negedge clk_i);
    #1;
    n_cmp++;
    if (obs !== RESET_WORD) begin
      n_err++;
      $display("FAIL reset_hold: got %b expected %b", obs, RESET_WORD);
    end
    @(negedge clk_i); rst_ni = 1'b1; #1;
    n_cmp++;
    if (obs !== exp_out(FETCH, 1'b1, 3'b000, 1'b0)) begin
      n_err++;
      $display("FAIL reset_release_fetch: got %b expected %b", obs, exp_out(FETCH, 1'b1, 3'b000, 1'b0));
    end
  endtask

  task automatic test_add_sub();
    st_t seq [5] = '{FETCH, DECODE, EXECR, ALUWB, FETCH};
    logic [14:0] exp;
    for (int t = 0; t < 2; t++) begin
      op_i = 7'b0110011; funct3_i = 3'b000; funct7b5_i = t[0]; zero_i = 1'b1;
      foreach (seq[i]) begin
        if (i > 0) begin @(negedge clk_i); #1; end
        exp = exp_out(seq[i], zero_i, (t == 0) ? 3'b000 : 3'b001, 1'b0);
        n_cmp++;
        if (obs !== exp) begin
          n_err++;
          $display("FAIL %s step %0d (%s): got %b expected %b",
                   (t == 0) ? "add" : "sub", i, seq[i].name(), obs, exp);
        end
      end
    end
  endtask

  typedef struct {
    logic [6:0] op;
    logic [2:0] f3;
    logic       f7;
    logic [2:0] alu;
  } alu_vec_t;

  task automatic test_alu_decode();
    alu_vec_t vec [6] = '{
      '{7'b0010011, 3'b000, 1'b1, 3'b000},  // addi with bit30 set: still add
      '{7'b0010011, 3'b100, 1'b0, 3'b100},  // xori
      '{7'b0010011, 3'b010, 1'b0, 3'b101},  // slti
      '{7'b0110011, 3'b110, 1'b0, 3'b011},  // or
      '{7'b0110011, 3'b111, 1'b1, 3'b010},  // and
      '{7'b0010011, 3'b110, 1'b1, 3'b011}   // ori
    };
    st_t seq [5];
    logic [14:0] exp;
    foreach (vec[v]) begin
      seq = '{FETCH, DECODE, (vec[v].op[5] ? EXECR : EXECI), ALUWB, FETCH};
      op_i = vec[v].op; funct3_i = vec[v].f3; funct7b5_i = vec[v].f7; zero_i = 1'b0;
      foreach (seq[i]) begin
        if (i > 0) begin @(negedge clk_i); #1; end
        exp = exp_out(seq[i], zero_i, vec[v].alu, 1'b0);
        n_cmp++;
        if (obs !== exp) begin
          n_err++;
          $display("FAIL alu_vec%0d step %0d (%s): got %b expected %b", v, i, seq[i].name(), obs, exp);
        end
      end
    end
  endtask

  task automatic test_mem();
    st_t lw_seq [6] = '{FETCH, DECODE, MEMADR, MEMREAD, MEMWB, FETCH};
    st_t sw_seq [5] = '{FETCH, DECODE, MEMADR, MEMWRITE, FETCH};
    logic [14:0] exp;
    op_i = 7'b0000011; funct3_i = 3'b010; funct7b5_i = 1'b0; zero_i = 1'b1;
    foreach (lw_seq[i]) begin
      if (i > 0) begin @(negedge clk_i); #1; end
      exp = exp_out(lw_seq[i], zero_i, 3'b000, 1'b0);
      n_cmp++;
      if (obs !== exp) begin
        n_err++;
        $display("FAIL lw step %0d (%s): got %b expected %b", i, lw_seq[i].name(), obs, exp);
      end
    end
    op_i = 7'b0100011;
    foreach (sw_seq[i]) begin
      if (i > 0) begin @(negedge clk_i); #1; end
      exp = exp_out(sw_seq[i], zero_i, 3'b000, 1'b0);
      n_cmp++;
      if (obs !== exp) begin
        n_err++;
        $display("FAIL sw step %0d (%s): got %b expected %b", i, sw_seq[i].name(), obs, exp);
      end
    end
  endtask

  task automatic test_branch_jump();
    st_t beq_seq [4] = '{FETCH, DECODE, BEQ, FETCH};
    st_t jal_seq [5] = '{FETCH, DECODE, JAL, ALUWB, FETCH};
    logic [14:0] exp;
    for (int t = 0; t < 2; t++) begin
      op_i = 7'b1100011; funct3_i = 3'b000; funct7b5_i = 1'b0; zero_i = (t == 0);
      foreach (beq_seq[i]) begin
        if (i > 0) begin @(negedge clk_i); #1; end
        exp = exp_out(beq_seq[i], zero_i, 3'b000, 1'b0);
        n_cmp++;
        if (obs !== exp) begin
          n_err++;
          $display("FAIL beq_zero%0d step %0d (%s): got %b expected %b",
                   zero_i, i, beq_seq[i].name(), obs, exp);
        end
      end
    end
    op_i = 7'b1101111; zero_i = 1'b0;
    foreach (jal_seq[i]) begin
      if (i > 0) begin @(negedge clk_i); #1; end
      exp = exp_out(jal_seq[i], zero_i, 3'b000, 1'b0);
      n_cmp++;
      if (obs !== exp) begin
        n_err++;
        $display("FAIL jal step %0d (%s): got %b expected %b", i, jal_seq[i].name(), obs, exp);
      end
    end
  endtask

  task automatic test_illegal();
    logic [6:0] ops [5]  = '{7'b0110011, 7'b0110011, 7'b0010011, 7'b0010011, 7'b0000000};
    logic [2:0] f3s [5]  = '{3'b001, 3'b011, 3'b101, 3'b001, 3'b000};
    st_t seq [3] = '{FETCH, DECODE, FETCH};
    logic [14:0] exp;
    foreach (ops[v]) begin
      op_i = ops[v]; funct3_i = f3s[v]; funct7b5_i = 1'b0; zero_i = 1'b1;
      foreach (seq[i]) begin
        if (i > 0) begin @(negedge clk_i); #1; end
        exp = exp_out(seq[i], zero_i, 3'b000, (i == 1));
        n_cmp++;
        if (obs !== exp) begin
          n_err++;
          $display("FAIL illegal%0d step %0d (%s): got %b expected %b", v, i, seq[i].name(), obs, exp);
        end
      end
    end
  endtask

  task automatic test_reset_mid_instr();
    st_t seq [5] = '{FETCH, DECODE, MEMADR, MEMWRITE, FETCH};
    logic [14:0] exp;
    op_i = 7'b0100011; funct3_i = 3'b010; funct7b5_i = 1'b0; zero_i = 1'b0;
    for (int i = 0; i < 4; i++) begin
      if (i > 0) begin @(negedge clk_i); #1; end
      exp = exp_out(seq[i], zero_i, 3'b000, 1'b0);
      n_cmp++;
      if (obs !== exp) begin
        n_err++;
        $display("FAIL sw_pre_reset step %0d (%s): got %b expected %b", i, seq[i].name(), obs, exp);
      end
    end
    rst_ni = 1'b0; #1;
    n_cmp++;
    if (obs !== RESET_WORD) begin
      n_err++;
      $display("FAIL reset_in_memwrite: got %b expected %b", obs, RESET_WORD);
    end
    @(negedge clk_i); rst_ni = 1'b1; #1;
    foreach (seq[i]) begin
      if (i > 0) begin @(negedge clk_i); #1; end
      exp = exp_out(seq[i], zero_i, 3'b000, 1'b0);
      n_cmp++;
      if (obs !== exp) begin
        n_err++;
        $display("FAIL sw_post_reset step %0d (%s): got %b expected %b", i, seq[i].name(), obs, exp);
      end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_add_sub();
    test_alu_decode();
    test_mem();
    test_branch_jump();
    test_illegal();
    test_reset_mid_instr();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
